// File: rtl/wb_stage.sv
// wb_stage: write-back stage of the MIPS pipeline, sole writer of the
// register file write port.
//
// Ports:
//   cpu_clk_50M, cpu_rst       clock, synchronous active-high reset
//   in_valid / in_ready        handshake with the MEM stage
//   in_wreg, in_wa             GPR write request and destination
//   in_alu_res                 non-load write data
//   in_is_load, in_ld_type     load flag and type (0 LB,1 LBU,2 LH,3 LHU,4 LW)
//   in_addr_lo                 low two bits of the load address
//   dm_rvalid, dm_rdata        data memory read return
//   rfwe, rfwa, rfwd           registered register file write
//   fwd_valid, fwd_wa, fwd_wd  forwarding copy of rfwe/rfwa/rfwd
//   ld_pending, ld_pending_wa  load waiting for data and its destination
//   ld_err                     one-cycle pulse: misaligned/illegal/timed-out load
//   retire_cnt                 count of performed register writes
module wb_stage #(
  parameter int LOAD_TIMEOUT = 16,
  parameter int CNT_W        = 32
) (
  input  logic             cpu_clk_50M,
  input  logic             cpu_rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_wreg,
  input  logic [4:0]       in_wa,
  input  logic [31:0]      in_alu_res,
  input  logic             in_is_load,
  input  logic [2:0]       in_ld_type,
  input  logic [1:0]       in_addr_lo,
  input  logic             dm_rvalid,
  input  logic [31:0]      dm_rdata,
  output logic             rfwe,
  output logic [4:0]       rfwa,
  output logic [31:0]      rfwd,
  output logic             fwd_valid,
  output logic [4:0]       fwd_wa,
  output logic [31:0]      fwd_wd,
  output logic             ld_pending,
  output logic [4:0]       ld_pending_wa,
  output logic             ld_err,
  output logic [CNT_W-1:0] retire_cnt
);

  localparam int TW = $clog2(LOAD_TIMEOUT + 1);
  localparam logic [TW-1:0] TLAST = TW'(LOAD_TIMEOUT - 1);

  typedef enum logic {IDLE, WAIT_LOAD} state_t;

  state_t      state, state_nx;
  logic [TW-1:0] tcnt, tcnt_nx;

  // fields of the load being waited on
  logic [2:0]  lat_type;
  logic [1:0]  lat_addr;
  logic [4:0]  lat_wa;
  logic        lat_wreg;
  logic        take_load;

  logic        rfwe_nx, ld_err_nx, pend_nx;
  logic [4:0]  rfwa_nx, pwa_nx;
  logic [31:0] rfwd_nx;
  logic [31:0] ld_data;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        accept, misaligned;

  assign in_ready  = (state == IDLE);
  assign accept    = in_valid && in_ready;
  assign fwd_valid = rfwe;
  assign fwd_wa    = rfwa;
  assign fwd_wd    = rfwd;

  always_comb begin
    misaligned = 1'b0;
    case (in_ld_type)
      3'd0, 3'd1: misaligned = 1'b0;
      3'd2, 3'd3: misaligned = in_addr_lo[0];
      3'd4:       misaligned = (in_addr_lo != 2'd0);
      default:    misaligned = 1'b1;
    endcase
  end

  always_comb begin
    byte_sel = dm_rdata[{lat_addr, 3'b000} +: 8];
    half_sel = dm_rdata[{lat_addr[1], 4'b0000} +: 16];
    case (lat_type)
      3'd0:    ld_data = {{24{byte_sel[7]}}, byte_sel};
      3'd1:    ld_data = {24'd0, byte_sel};
      3'd2:    ld_data = {{16{half_sel[15]}}, half_sel};
      3'd3:    ld_data = {16'd0, half_sel};
      default: ld_data = dm_rdata;
    endcase
  end

  always_comb begin
    state_nx  = state;
    tcnt_nx   = tcnt;
    rfwe_nx   = 1'b0;
    rfwa_nx   = rfwa;
    rfwd_nx   = rfwd;
    ld_err_nx = 1'b0;
    pend_nx   = ld_pending;
    pwa_nx    = ld_pending_wa;
    take_load = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (!in_is_load) begin
            if (in_wreg && (in_wa != 5'd0)) begin
              rfwe_nx = 1'b1;
              rfwa_nx = in_wa;
              rfwd_nx = in_alu_res;
            end
          end else if (misaligned) begin
            ld_err_nx = 1'b1;
          end else begin
            take_load = 1'b1;
            state_nx  = WAIT_LOAD;
            pend_nx   = 1'b1;
            pwa_nx    = in_wa;
            tcnt_nx   = '0;
          end
        end
      end
      WAIT_LOAD: begin
        if (dm_rvalid) begin
          state_nx = IDLE;
          pend_nx  = 1'b0;
          if (lat_wreg && (lat_wa != 5'd0)) begin
            rfwe_nx = 1'b1;
            rfwa_nx = lat_wa;
            rfwd_nx = ld_data;
          end
        end else if (tcnt == TLAST) begin
          state_nx  = IDLE;
          pend_nx   = 1'b0;
          ld_err_nx = 1'b1;
        end else begin
          tcnt_nx = tcnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      state         <= IDLE;
      tcnt          <= '0;
      rfwe          <= 1'b0;
      rfwa          <= '0;
      rfwd          <= '0;
      ld_err        <= 1'b0;
      ld_pending    <= 1'b0;
      ld_pending_wa <= '0;
      retire_cnt    <= '0;
      lat_type      <= '0;
      lat_addr      <= '0;
      lat_wa        <= '0;
      lat_wreg      <= 1'b0;
    end else begin
      state         <= state_nx;
      tcnt          <= tcnt_nx;
      rfwe          <= rfwe_nx;
      rfwa          <= rfwa_nx;
      rfwd          <= rfwd_nx;
      ld_err        <= ld_err_nx;
      ld_pending    <= pend_nx;
      ld_pending_wa <= pwa_nx;
      // counts in the same cycle the write becomes visible
      retire_cnt    <= retire_cnt + CNT_W'(rfwe_nx);
      if (take_load) begin
        lat_type <= in_ld_type;
        lat_addr <= in_addr_lo;
        lat_wa   <= in_wa;
        lat_wreg <= in_wreg;
      end
    end
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Write-back stage of the MIPS pipeline and the single writer of the register file write port (rfwe/rfwa/rfwd).
- Takes retiring instructions from the MEM stage through a valid/ready handshake and waits for load data from data memory when needed.
- Formats load data (byte/half/word, signed or unsigned) and emits one registered write per instruction.
- Also exports forwarding and load-pending hazard information to the decode stage.

Parameters:
- LOAD_TIMEOUT, 16: maximum cycles spent in WAIT_LOAD before the load is abandoned with ld_err.
- CNT_W, 32: width of the retire counter.

Ports:
- cpu_clk_50M  in  1  single clock; all state updates on its rising edge.
- cpu_rst  in  1  synchronous, active-high reset.
- in_valid  in  1  MEM stage presents an instruction.
- in_ready  out  1  stage can accept an instruction this cycle.
- in_wreg  in  1  instruction writes a GPR.
- in_wa  in  5  destination register index (reg_enum).
- in_alu_res  in  32  ALU result / non-load write data.
- in_is_load  in  1  instruction is a load.
- in_ld_type  in  3  0=LB, 1=LBU, 2=LH, 3=LHU, 4=LW; 5-7 illegal.
- in_addr_lo  in  2  low two bits of the load address.
- dm_rvalid  in  1  data memory read data valid.
- dm_rdata  in  32  data memory read data, little-endian word.
- rfwe  out  1  register file write enable.
- rfwa  out  5  register file write address.
- rfwd  out  32  register file write data.
- fwd_valid  out  1  same as rfwe; forwarding source is valid.
- fwd_wa  out  5  same as rfwa.
- fwd_wd  out  32  same as rfwd.
- ld_pending  out  1  a load is waiting for data.
- ld_pending_wa  out  5  destination of the pending load.
- ld_err  out  1  one-cycle pulse on misaligned, illegal, or timed-out load.
- retire_cnt  out  CNT_W  count of performed register writes.

Behaviour:
- Reset (cpu_rst=1 at an edge):
  - State goes to IDLE.
  - rfwe, rfwa, rfwd, ld_pending, ld_pending_wa, ld_err, retire_cnt and the timeout counter all clear to 0.
  - Any pending load is dropped; a dm_rvalid arriving afterwards is ignored.
- State machine has two states, IDLE and WAIT_LOAD.
- in_ready = 1 in IDLE, 0 in WAIT_LOAD. An accept happens when in_valid && in_ready at an edge.
- All outputs are registered. rfwe/ld_err pulse for exactly one cycle; the fwd_* ports mirror the rf* ports.
- Non-load accept:
  - If in_wreg=1 and in_wa!=0, the next cycle drives rfwe=1, rfwa=in_wa, rfwd=in_alu_res.
  - Otherwise rfwe=0 next cycle.
  - Latency is 1 cycle; back-to-back accepts give back-to-back writes.
- Load accept, alignment check:
  - LH/LHU with addr_lo[0]=1, LW with addr_lo!=0, or an illegal ld_type → ld_err=1 next cycle, no write, stay in IDLE.
- Load accept, legal:
  - Move to WAIT_LOAD, latch type/addr_lo/wa, set ld_pending=1 and ld_pending_wa=in_wa, clear the timeout counter.
- In WAIT_LOAD with dm_rvalid=1:
  - Next cycle rfwe=1 (suppressed if wa=0 or wreg=0), rfwd = formatted data.
  - Return to IDLE and clear ld_pending.
  - Minimum load latency is 2 cycles from accept.
- In WAIT_LOAD without dm_rvalid:
  - The timeout counter increments.
  - When it reaches LOAD_TIMEOUT-1 without data: ld_err pulses next cycle, state returns to IDLE, ld_pending clears, no write.
- dm_rvalid while in IDLE is ignored.
- Load formatting (sel = addr_lo):
  - LB: byte dm_rdata[8*sel+:8], sign-extended.
  - LBU: the same byte, zero-extended.
  - LH: half dm_rdata[16*sel[1]+:16], sign-extended.
  - LHU: the same half, zero-extended.
  - LW: the full word.
- retire_cnt increments by 1 on every cycle with rfwe=1 and wraps modulo 2^CNT_W.
- Writes to register 0 are never issued (rfwe stays 0).

Test Plan:
- ALU write: accept wreg=1, wa=8, alu_res=0x12345678 → next cycle rfwe=1, rfwa=8, rfwd=0x12345678, fwd_* identical, retire_cnt=1. Three back-to-back accepts → three consecutive writes, retire_cnt=3.
- Byte loads: LB addr_lo=3, wa=9, dm_rvalid 2 cycles after accept with dm_rdata=0x80FF0000 → in_ready=0 and ld_pending=1 (wa 9) while waiting, then rfwd=0xFFFFFF80. Same stimulus as LBU → rfwd=0x00000080.
- Half-word loads: LH addr_lo=2, dm_rdata=0x80011234 → rfwd=0xFFFF8001. LHU addr_lo=0 → 0x00001234. LHU addr_lo=1 → ld_err pulse next cycle, rfwe=0, in_ready stays 1.
- Load timeout: LW addr_lo=0 with no dm_rvalid → ld_err pulses after 16 waiting cycles, then in_ready=1, ld_pending=0, no write. A late dm_rvalid is ignored.
- Register 0: accept wreg=1, wa=0 (ALU op and LW) → rfwe never asserted, retire_cnt unchanged.
- Reset mid-load: assert cpu_rst for one cycle during WAIT_LOAD, then dm_rvalid=1 → no write, all outputs 0, in_ready=1 the cycle after reset.
